// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise and filter the pads, decode 11-bit frames,
// and queue good scancodes in a small first-word-fall-through FIFO.
module ps2_kbd_rx #(
  parameter int unsigned C_clk_hz     = 25000000,
  parameter int unsigned C_filter     = 8,
  parameter int unsigned C_timeout_us = 2000,
  parameter int unsigned C_fifo_log2  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned TimeoutCycles = (C_clk_hz / 1000000) * C_timeout_us;
  localparam int unsigned ToW           = $clog2(TimeoutCycles + 1);
  localparam int unsigned FltW          = $clog2(C_filter + 1);
  localparam int unsigned Depth         = 1 << C_fifo_log2;
  localparam int unsigned PtrW          = C_fifo_log2 + 1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Input path: two-flop synchronisers, index 0 = clock line, 1 = data line
  logic [1:0] sync0_q, sync1_q;
  logic [1:0] filt_q;
  logic [FltW-1:0] fcnt_q [2];
  logic fclk_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q     <= 2'b11;
      sync1_q     <= 2'b11;
      filt_q      <= 2'b11;
      fcnt_q[0]   <= '0;
      fcnt_q[1]   <= '0;
      fclk_prev_q <= 1'b1;
    end else begin
      sync0_q     <= {ps2_data, ps2_clk};
      sync1_q     <= sync0_q;
      fclk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync1_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FltW'(C_filter - 1)) begin
          filt_q[i] <= sync1_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + FltW'(1);
        end
      end
    end
  end

  logic evt, bit_in;
  assign evt    = fclk_prev_q & ~filt_q[0];
  assign bit_in = filt_q[1];

  // Frame decoder
  state_e         state_q;
  logic [7:0]     shift_q;
  logic [2:0]     bitcnt_q;
  logic           par_ok_q;
  logic [ToW-1:0] to_cnt_q;
  logic           to_hit;
  logic           push;

  assign to_hit = (state_q != StIdle) && !evt && (to_cnt_q == ToW'(TimeoutCycles - 1));
  assign push   = (state_q == StStop) && evt && bit_in && par_ok_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      par_ok_q  <= 1'b0;
      to_cnt_q  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (state_q == StIdle || evt) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + ToW'(1);
      end
      if (to_hit) begin
        state_q   <= StIdle;
        frame_err <= 1'b1;
        to_cnt_q  <= '0;
      end else if (evt) begin
        unique case (state_q)
          StIdle: begin
            if (!bit_in) begin
              shift_q  <= '0;
              bitcnt_q <= '0;
              state_q  <= StData;
            end
          end
          StData: begin
            shift_q  <= {bit_in, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            par_ok_q <= ^{shift_q, bit_in};
            state_q  <= StStop;
          end
          StStop: begin
            if (!(bit_in && par_ok_q)) frame_err <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // FIFO with an extra wrap bit on each pointer to tell full from empty
  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic            empty, full, pop, wr_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                 (wptr_q[PtrW-2:0] == rptr_q[PtrW-2:0]);
  assign pop   = rd && !empty;
  assign wr_en = push && (!full || pop);
  assign valid = !empty;
  assign dout  = empty ? 8'h00 : mem_q[rptr_q[PtrW-2:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PtrW'(1);
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[PtrW-2:0]] <= shift_q;
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed and randomized frame stimulus for ps2_kbd_rx against a queue-based model.
module tb_ps2_kbd_rx;

  localparam int unsigned ClkHz = 1000000;
  localparam int unsigned TimeoutUs = 2000;
  localparam int unsigned Limit = (ClkHz / 1000000) * TimeoutUs;
  localparam int unsigned FilterN = 8;
  localparam int unsigned Lat = 2 + FilterN + 1;  // pad fall -> registered effect
  localparam int unsigned H = 40;                 // PS/2 half period in clocks

  logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, rd = 1'b0;
  logic [7:0] dout;
  logic valid, frame_err, overflow;

  int unsigned cyc = 0, n_assert = 0, n_fail = 0;
  int unsigned err_pulses = 0, err_hi = 0, err_cyc = 0, vrise_cyc = 0, last_fall = 0;
  logic fe_prev = 1'b0, v_prev = 1'b0;
  logic [7:0] model_q[$];
  bit model_ovf;

  ps2_kbd_rx #(
    .C_clk_hz(ClkHz), .C_filter(FilterN), .C_timeout_us(TimeoutUs), .C_fifo_log2(3)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd(rd),
    .dout(dout), .valid(valid), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_err) begin
      err_hi++;
      err_cyc = cyc;
    end
    if (frame_err && !fe_prev) err_pulses++;
    if (valid && !v_prev) vrise_cyc = cyc;
    fe_prev = frame_err;
    v_prev  = valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bits go out LSB first: start, 8 data, odd parity, stop.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit, input bit rd_on_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      tick(H / 2);
      ps2_clk = 1'b0;
      last_fall = cyc;
      if (rd_on_stop && i == 10) begin
        tick(Lat - 1);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        tick(H - Lat);
      end else begin
        tick(H);
      end
      ps2_clk = 1'b1;
      if (i == glitch_bit) begin
        tick(10);
        ps2_clk = 1'b0;
        tick(5);
        ps2_clk = 1'b1;
        tick(H / 2 - 15);
      end else begin
        tick(H / 2);
      end
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11, -1, 1'b0);
    tick(H);
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check({tag, "_valid"}, valid, 1'b1);
    check({tag, "_dout"}, dout, exp);
    @(posedge clk);
    #1 rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  initial begin
    int unsigned e0;
    logic [7:0] b;
    int kind, npop;

    // Reset state
    tick(5);
    @(negedge clk);
    check("rst_valid", valid, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    tick(20);

    // Good frame 0x1C, latency from stop-bit clock fall
    e0 = err_pulses;
    send_good(8'h1C);
    check("t1_latency", vrise_cyc - last_fall, Lat);
    check("t1_err", err_pulses - e0, 0);
    pop("t1", 8'h1C);
    @(negedge clk);
    check("t1_empty", valid, 1'b0);

    // Parity error, then good 0xF0
    e0 = err_pulses;
    send_frame(8'h1C, 1'b1, 1'b0, 11, -1, 1'b0);
    tick(H);
    check("t2_err", err_pulses - e0, 1);
    check("t2_err_time", err_cyc - last_fall, Lat);
    check("t2_valid", valid, 1'b0);
    send_good(8'hF0);
    pop("t2", 8'hF0);

    // Short clock glitches in idle and mid-frame
    e0 = err_pulses;
    ps2_clk = 1'b0;
    tick(5);
    ps2_clk = 1'b1;
    tick(30);
    check("t3_idle_valid", valid, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 11, 3, 1'b0);
    tick(H);
    check("t3_err", err_pulses - e0, 0);
    pop("t3", 8'h5A);

    // Timeout after 4 data bits
    e0 = err_pulses;
    send_frame(8'h12, 1'b0, 1'b0, 5, -1, 1'b0);
    tick(Limit + Limit / 20);
    check("t4_err", err_pulses - e0, 1);
    check("t4_err_time", (err_cyc - last_fall >= Limit + Lat - 1) &&
                         (err_cyc - last_fall <= Limit + Lat + 1), 1'b1);
    check("t4_valid", valid, 1'b0);
    send_good(8'h12);
    pop("t4", 8'h12);

    // rd when empty is ignored
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    @(negedge clk);
    check("t5_rd_empty", valid, 1'b0);

    // Overflow: 9 frames without reads
    for (int i = 1; i <= 8; i++) send_good(8'(i));
    check("t5_ovf_before", overflow, 1'b0);
    send_good(8'h09);
    check("t5_ovf", overflow, 1'b1);
    for (int i = 1; i <= 8; i++) pop("t5", 8'(i));
    @(negedge clk);
    check("t5_empty", valid, 1'b0);
    check("t5_ovf_sticky", overflow, 1'b1);

    // Reset mid-frame
    e0 = err_pulses;
    send_frame(8'h33, 1'b0, 1'b0, 5, -1, 1'b0);
    reset = 1'b1;
    tick(3);
    @(negedge clk);
    check("t6_rst_valid", valid, 1'b0);
    check("t6_rst_dout", dout, 8'h00);
    check("t6_rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    tick(Limit + 100);
    check("t6_no_err", err_pulses - e0, 0);
    send_good(8'h29);
    pop("t6", 8'h29);
    @(negedge clk);
    check("t6_single", valid, 1'b0);

    // Full FIFO with a pop in the push cycle: push accepted, no overflow
    for (int i = 1; i <= 8; i++) send_good(8'h40 + 8'(i));
    send_frame(8'h49, 1'b0, 1'b0, 11, -1, 1'b1);
    tick(H);
    check("t7_ovf", overflow, 1'b0);
    for (int i = 2; i <= 9; i++) pop("t7", 8'h40 + 8'(i));

    // Randomized frames against the queue model
    e0 = err_pulses;
    model_ovf = 1'b0;
    npop = 0;
    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      kind = int'($urandom_range(0, 4));
      if (kind <= 2) begin
        if (model_q.size() < 8) model_q.push_back(b);
        else model_ovf = 1'b1;
      end else begin
        npop++;
      end
      send_frame(b, kind == 3, kind == 4, 11, -1, 1'b0);
      tick(H);
      for (int j = int'($urandom_range(0, 1)); j > 0; j--) begin
        if (model_q.size() > 0) begin
          pop("rnd", model_q.pop_front());
        end else begin
          rd = 1'b1;
          tick(1);
          rd = 1'b0;
          @(negedge clk);
          check("rnd_empty", valid, 1'b0);
        end
      end
    end
    check("rnd_err", err_pulses - e0, npop);
    check("rnd_ovf", overflow, model_ovf);
    while (model_q.size() > 0) pop("rnd_drain", model_q.pop_front());
    @(negedge clk);
    check("rnd_final_empty", valid, 1'b0);
    check("err_one_cycle", err_hi, err_pulses);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
